// File: rtl/edge_detect_pkg.sv
// Shared mode encodings and sizing helpers for the multi-channel edge detector.
package edge_detect_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Filter counter must hold 0..FILTER_CYCLES-1 and be at least one bit wide.
  function automatic int unsigned fcnt_width(input int unsigned filter_cycles);
    int unsigned w;
    w = clog2(filter_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// One channel: synchroniser, debounce filter, mode-gated edge pulse, sticky flag
// and saturating event counter.
module edge_detect_channel
  import edge_detect_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             level,
  output logic             pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned        FCNT_W    = fcnt_width(FILTER_CYCLES);
  localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [FCNT_W-1:0]      fcnt;
  logic                   sync_out;
  logic                   toggle;
  logic                   rise_en;
  logic                   fall_en;
  logic                   event_next;

  assign sync_out = sync[SYNC_STAGES-1];

  always_comb begin
    toggle     = (sync_out != level) && (fcnt == FCNT_LAST);
    rise_en    = (mode == MODE_RISE) || (mode == MODE_BOTH);
    fall_en    = (mode == MODE_FALL) || (mode == MODE_BOTH);
    event_next = toggle && (level ? fall_en : rise_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      fcnt   <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
      sticky <= 1'b0;
      count  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};

      if (sync_out == level) begin
        fcnt <= '0;
      end else if (toggle) begin
        fcnt  <= '0;
        level <= ~level;
      end else begin
        fcnt <= fcnt + 1'b1;
      end

      pulse <= event_next;

      // Sticky and count follow the registered pulse, so a clear that lands in
      // the pulse cycle still keeps that event.
      if (pulse)      sticky <= 1'b1;
      else if (clear) sticky <= 1'b0;

      if (clear)                    count <= pulse ? CNT_W'(1) : '0;
      else if (pulse && count != '1) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel slices of the buses plus the OR of
// all sticky flags as an interrupt request.
module multi_edge_detect
  import edge_detect_pkg::*;
#(
  parameter int unsigned CHANNELS      = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       sticky,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic                      any_event
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_detect_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .in    (in[i]),
      .mode  (mode[2*i +: 2]),
      .clear (clear[i]),
      .level (level[i]),
      .pulse (pulse[i]),
      .sticky(sticky[i]),
      .count (count[i*CNT_W +: CNT_W])
    );
  end

  assign any_event = |sticky;

endmodule
